// File: rtl/ram_stream_pkg.sv
// Shared types and helpers for the RAM-to-UART streamer.
// Optional checksum byte is enabled by defining RAM_STREAM_CHECKSUM_EN.
package ram_stream_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_READ,
    S_WAIT_DATA,
    S_LOAD,
    S_SEND,
    S_WAIT_TX,
    S_GAP,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [7:0] CHECKSUM_INIT = 8'h00;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/byte_serializer.sv
// Holds one RAM word and presents it MSB byte first; shift moves to the next byte.
module byte_serializer
  import ram_stream_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] word_i,
  output logic [7:0]       byte_o,
  output logic             last_o
);

  localparam int BPW  = bytes_per_word(WIDTH);
  localparam int IDXW = $clog2(BPW) + 1;

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load_i) begin
      shreg_d = word_i;
      idx_d   = IDXW'(BPW - 1);
    end else if (shift_i) begin
      shreg_d = shreg_q << 8;
      idx_d   = idx_q - IDXW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign byte_o = shreg_q[WIDTH-1 -: 8];
  assign last_o = (idx_q == '0);

endmodule

// File: rtl/ram_uart_streamer.sv
// Streams a block of RAM words to uart_tx byte by byte, paced by tx_busy.
// Define RAM_STREAM_CHECKSUM_EN to append an XOR checksum byte after the data.
module ram_uart_streamer
  import ram_stream_pkg::*;
#(
  parameter int RAM_WIDTH    = 24,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = 1,
  parameter int GAP_CYCLES   = 0,
  localparam int ADDR_BITS   = $clog2(RAM_DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [ADDR_BITS:0]   length,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic                 ram_rd_en,
  input  logic [RAM_WIDTH-1:0] ram_data,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 busy,
  output logic                 done
);

  if ((RAM_WIDTH % 8) != 0 || RAM_WIDTH < 8) begin : g_width_chk
    $error("RAM_WIDTH must be a non-zero multiple of 8");
  end

  localparam logic [ADDR_BITS:0]   DEPTH_L  = (ADDR_BITS+1)'(RAM_DEPTH);
  localparam logic [ADDR_BITS:0]   WCNT_ONE = (ADDR_BITS+1)'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_MAX = ADDR_BITS'(RAM_DEPTH - 1);

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS:0]   wcnt_q, wcnt_d;
  logic [31:0]          lat_q, lat_d;
  logic [31:0]          gap_q, gap_d;
  logic                 first_q, first_d;
  logic                 done_q;
  logic                 ser_load, ser_shift, ser_last, route;
  logic [RAM_WIDTH-1:0] ser_word;

`ifdef RAM_STREAM_CHECKSUM_EN
  logic [7:0] cks_q;
  logic       cks_phase_q, cks_phase_d;
  logic       cks_load;
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wcnt_d    = wcnt_q;
    lat_d     = lat_q;
    gap_d     = gap_q;
    first_d   = first_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;
    tx_start  = 1'b0;
    route     = 1'b0;
`ifdef RAM_STREAM_CHECKSUM_EN
    cks_phase_d = cks_phase_q;
    cks_load    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d = base_addr;
          wcnt_d = (length > DEPTH_L) ? DEPTH_L : length;
`ifdef RAM_STREAM_CHECKSUM_EN
          cks_phase_d = 1'b0;
          if (length == '0) begin
            cks_load    = 1'b1;
            cks_phase_d = 1'b1;
            state_d     = S_SEND;
          end else begin
            state_d = S_READ;
          end
`else
          state_d = (length == '0) ? S_DONE : S_READ;
`endif
        end
      end
      S_READ: begin
        lat_d   = '0;
        state_d = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (lat_q == 32'(READ_LATENCY - 1)) begin
          lat_d   = '0;
          state_d = S_LOAD;
        end else begin
          lat_d = lat_q + 32'd1;
        end
      end
      S_LOAD: begin
        ser_load = 1'b1;
        state_d  = S_SEND;
      end
      S_SEND: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          first_d  = 1'b1;
          state_d  = S_WAIT_TX;
        end
      end
      S_WAIT_TX: begin
        // uart_tx may not have raised tx_busy yet in the first cycle
        if (first_q) begin
          first_d = 1'b0;
        end else if (!tx_busy) begin
          if (GAP_CYCLES > 0) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            route = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == 32'(GAP_CYCLES - 1)) begin
          gap_d = '0;
          route = 1'b1;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      S_NEXT: begin
        addr_d  = (addr_q == ADDR_MAX) ? '0 : addr_q + ADDR_BITS'(1);
        wcnt_d  = wcnt_q - WCNT_ONE;
        state_d = S_READ;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (route) begin
`ifdef RAM_STREAM_CHECKSUM_EN
      if (cks_phase_q) begin
        state_d = S_DONE;
      end else
`endif
      if (!ser_last) begin
        ser_shift = 1'b1;
        state_d   = S_SEND;
      end else if (wcnt_q != WCNT_ONE) begin
        state_d = S_NEXT;
      end else begin
`ifdef RAM_STREAM_CHECKSUM_EN
        cks_load    = 1'b1;
        cks_phase_d = 1'b1;
        state_d     = S_SEND;
`else
        state_d = S_DONE;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wcnt_q  <= '0;
      lat_q   <= '0;
      gap_q   <= '0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      lat_q   <= lat_d;
      gap_q   <= gap_d;
      first_q <= first_d;
      done_q  <= (state_q == S_DONE);
    end
  end

`ifdef RAM_STREAM_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cks_q       <= CHECKSUM_INIT;
      cks_phase_q <= 1'b0;
    end else begin
      cks_phase_q <= cks_phase_d;
      if (state_q == S_IDLE && start) begin
        cks_q <= CHECKSUM_INIT;
      end else if (tx_start && !cks_phase_q) begin
        cks_q <= cks_q ^ tx_data;
      end
    end
  end

  // The checksum byte is loaded into the top byte of the serializer
  assign ser_word = cks_load
                  ? (RAM_WIDTH'((state_q == S_IDLE) ? CHECKSUM_INIT : cks_q) << (RAM_WIDTH - 8))
                  : ram_data;
`else
  assign ser_word = ram_data;
`endif

  byte_serializer #(
    .WIDTH (RAM_WIDTH)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef RAM_STREAM_CHECKSUM_EN
    .load_i  (ser_load | cks_load),
`else
    .load_i  (ser_load),
`endif
    .shift_i (ser_shift),
    .word_i  (ser_word),
    .byte_o  (tx_data),
    .last_o  (ser_last)
  );

  assign ram_addr  = addr_q;
  assign ram_rd_en = (state_q == S_READ);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule
